// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM states, nibble width and
// helpers that derive the nibble count and counter width from the operand width.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    function automatic int nibCount(input int width);
        return width / NIBBLE_W;
    endfunction

    // One extra bit keeps the counter at least one bit wide when NIB = 1.
    function automatic int cntWidth(input int width);
        return $clog2(width / NIBBLE_W) + 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand and result handshakes of the digit-serial adder, bundled as one interface.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );

endinterface

// File: rtl/nibble_serial_adder_cla.sv
// Gate-level 4-bit carry-lookahead adder; every carry is flattened to
// generate/propagate terms so the path depth does not grow with bit position.
module carry_lookahead_4_bit_adder_gatelevel (
    output logic [3:0] S,
    output logic       C4,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = A & B;
    assign w_p = A ^ B;

    assign w_c[0] = C0;
    assign w_c[1] = w_g[0] | (w_p[0] & C0);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & C0);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & C0);
    assign C4     = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & C0);

    assign S = w_p ^ w_c;

endmodule

// File: rtl/nibble_serial_adder.sv
// Digit-serial adder: steps both operands LSB-nibble-first through one 4-bit CLA,
// carrying between nibbles, and returns sum/carry/overflow over a handshake.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    nibble_serial_adder_if.slave bus
);
    localparam int NIB   = nibCount(WIDTH);
    localparam int CNT_W = cntWidth(WIDTH);

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_sumNext;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_ovf;
    logic             r_inReady;
    logic             r_outValid;
    logic             r_busy;
    logic [3:0]       w_aNib;
    logic [3:0]       w_bNib;
    logic [3:0]       w_s;
    logic             w_c4;
    logic             w_lastNib;
    logic             w_accept;

    assign w_aNib    = r_a[NIBBLE_W-1:0];
    assign w_bNib    = r_b[NIBBLE_W-1:0];
    assign w_lastNib = (r_cnt == CNT_W'(NIB - 1));
    assign w_accept  = (r_state == IDLE) && bus.in_valid;

    carry_lookahead_4_bit_adder_gatelevel u_cla (
        .S  (w_s),
        .C4 (w_c4),
        .A  (w_aNib),
        .B  (w_bNib),
        .C0 (r_carry)
    );

    // The new nibble enters the sum register from the top, so after NIB steps
    // nibble 0 has reached the bottom.
    if (NIB == 1) begin : gSingle
        assign w_sumNext = w_s;
    end else begin : gMulti
        assign w_sumNext = {w_s, r_sum[WIDTH-1:NIBBLE_W]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_inReady  <= (w_nextState == IDLE);
            r_outValid <= (w_nextState == DONE);
            r_busy     <= (w_nextState != IDLE);
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid)  w_nextState = RUN;
            RUN:     if (w_lastNib)     w_nextState = DONE;
            DONE:    if (bus.out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= bus.cin;
            r_ovf   <= 1'b0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> NIBBLE_W;
            r_b     <= r_b >> NIBBLE_W;
            r_sum   <= w_sumNext;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_carry <= w_c4;
            // On the top nibble the operand MSBs and the final sum MSB are all in view.
            if (w_lastNib) begin
                r_ovf <= (w_aNib[3] == w_bNib[3]) && (w_s[3] != w_aNib[3]);
            end
        end
    end

    assign bus.in_ready  = r_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.busy      = r_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_carry;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: a 16-bit and a 4-bit instance share
// clock and reset; expected results come from a plain arithmetic model.
module tb_nibble_serial_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } result16_t;

    typedef struct {
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } result4_t;

    logic clk = 1'b0;
    logic rst;
    int   cycle = 0;
    int   testsRun = 0;
    int   failures = 0;
    int   acceptCycle16;
    int   acceptCycle4;

    result16_t q16[$];
    result4_t  q4[$];
    result16_t exp16;
    result4_t  exp4;
    result16_t holdExp;

    nibble_serial_adder_if #(.WIDTH(16)) if16 ();
    nibble_serial_adder_if #(.WIDTH(4))  if4 ();

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16.slave)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic result16_t model16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        result16_t   r;
        logic [16:0] t;
        t      = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        r.sum  = t[15:0];
        r.cout = t[16];
        r.ovf  = (a[15] == b[15]) && (t[15] != a[15]);
        return r;
    endfunction

    function automatic result4_t model4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        result4_t   r;
        logic [4:0] t;
        t      = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        r.sum  = t[3:0];
        r.cout = t[4];
        r.ovf  = (a[3] == b[3]) && (t[3] != a[3]);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Results are popped a little after the falling edge so that handshake
    // inputs changed on that edge have settled.
    always @(negedge clk) begin
        #1;
        if (if16.out_valid && if16.out_ready) begin
            if (q16.size() == 0) begin
                checkOutput("unexpected16", 1, 0);
            end else begin
                exp16 = q16.pop_front();
                checkOutput("sum16",  {16'd0, if16.sum}, {16'd0, exp16.sum});
                checkOutput("cout16", {31'd0, if16.cout}, {31'd0, exp16.cout});
                checkOutput("ovf16",  {31'd0, if16.ovf},  {31'd0, exp16.ovf});
            end
        end
        if (if4.out_valid && if4.out_ready) begin
            if (q4.size() == 0) begin
                checkOutput("unexpected4", 1, 0);
            end else begin
                exp4 = q4.pop_front();
                checkOutput("sum4",  {28'd0, if4.sum}, {28'd0, exp4.sum});
                checkOutput("cout4", {31'd0, if4.cout}, {31'd0, exp4.cout});
                checkOutput("ovf4",  {31'd0, if4.ovf},  {31'd0, exp4.ovf});
            end
        end
    end

    task automatic driveOp16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int guard = 0;
        while (!if16.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) checkOutput("ready16_timeout", 0, 1);
        if16.in_valid = 1'b1;
        if16.a        = a;
        if16.b        = b;
        if16.cin      = cin;
        q16.push_back(model16(a, b, cin));
        @(negedge clk);
        if16.in_valid = 1'b0;
        acceptCycle16 = cycle;
    endtask

    task automatic awaitResult16();
        int guard = 0;
        while (!if16.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("latency16", cycle - acceptCycle16 + 1, 5);
    endtask

    task automatic drain16();
        int guard = 0;
        while ((q16.size() != 0 || if16.out_valid) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) checkOutput("drain16_timeout", 0, 1);
    endtask

    task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        driveOp16(a, b, cin);
        awaitResult16();
        drain16();
    endtask

    task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        int guard = 0;
        while (!if4.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if4.in_valid = 1'b1;
        if4.a        = a;
        if4.b        = b;
        if4.cin      = cin;
        q4.push_back(model4(a, b, cin));
        @(negedge clk);
        if4.in_valid = 1'b0;
        acceptCycle4 = cycle;
        guard = 0;
        while (!if4.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("latency4", cycle - acceptCycle4 + 1, 2);
        guard = 0;
        while ((q4.size() != 0 || if4.out_valid) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) checkOutput("drain4_timeout", 0, 1);
    endtask

    initial begin
        rst           = 1'b1;
        if16.in_valid = 1'b0;
        if16.a        = '0;
        if16.b        = '0;
        if16.cin      = 1'b0;
        if16.out_ready = 1'b1;
        if4.in_valid  = 1'b0;
        if4.a         = '0;
        if4.b         = '0;
        if4.cin       = 1'b0;
        if4.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        checkOutput("rst_in_ready",  {31'd0, if16.in_ready},  1);
        checkOutput("rst_out_valid", {31'd0, if16.out_valid}, 0);
        checkOutput("rst_busy",      {31'd0, if16.busy},      0);
        checkOutput("rst_sum",       {16'd0, if16.sum},       0);
        checkOutput("rst_cout",      {31'd0, if16.cout},      0);
        checkOutput("rst_ovf",       {31'd0, if16.ovf},       0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus16(16'h1234, 16'h4321, 1'b0);
        applyStimulus16(16'hFFFF, 16'h0001, 1'b0);
        applyStimulus16(16'h7FFF, 16'h0001, 1'b0);
        applyStimulus16(16'h0000, 16'hFFFF, 1'b1);
        applyStimulus16(16'h8000, 16'h8000, 1'b0);

        // Stall the consumer and try to push a new pair while the result waits.
        if16.out_ready = 1'b0;
        holdExp = model16(16'h8001, 16'h8001, 1'b0);
        driveOp16(16'h8001, 16'h8001, 1'b0);
        awaitResult16();
        if16.in_valid = 1'b1;
        if16.a        = 16'h1111;
        if16.b        = 16'h2222;
        if16.cin      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("hold_sum",       {16'd0, if16.sum},       {16'd0, holdExp.sum});
            checkOutput("hold_cout",      {31'd0, if16.cout},      {31'd0, holdExp.cout});
            checkOutput("hold_ovf",       {31'd0, if16.ovf},       {31'd0, holdExp.ovf});
            checkOutput("hold_in_ready",  {31'd0, if16.in_ready},  0);
            checkOutput("hold_out_valid", {31'd0, if16.out_valid}, 1);
        end
        if16.in_valid  = 1'b0;
        if16.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", {31'd0, if16.in_ready}, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("release_busy",      {31'd0, if16.busy},      0);
            checkOutput("release_out_valid", {31'd0, if16.out_valid}, 0);
        end
        checkOutput("hold_drained", q16.size(), 0);

        // Abort during the third nibble; the pending result must never appear.
        driveOp16(16'hAAAA, 16'h5555, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(q16.pop_back());
        checkOutput("abort_in_ready",  {31'd0, if16.in_ready},  1);
        checkOutput("abort_out_valid", {31'd0, if16.out_valid}, 0);
        checkOutput("abort_busy",      {31'd0, if16.busy},      0);
        checkOutput("abort_sum",       {16'd0, if16.sum},       0);
        repeat (6) begin
            @(negedge clk);
            checkOutput("abort_quiet", {31'd0, if16.out_valid}, 0);
        end
        applyStimulus16(16'h0F0F, 16'h00F1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus16(16'($urandom()), 16'($urandom()), 1'($urandom()));
        end

        applyStimulus4(4'h9, 4'h8, 1'b1);
        applyStimulus4(4'hF, 4'h0, 1'b1);
        applyStimulus4(4'h7, 4'h1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus4(4'($urandom()), 4'($urandom()), 1'($urandom()));
        end

        repeat (3) @(negedge clk);
        checkOutput("final_q16_empty", q16.size(), 0);
        checkOutput("final_q4_empty",  q4.size(),  0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
